// File: rtl/dmem_lane_arbiter.sv
// Arbitrates EVEN/ODD lane accesses onto one single-ported data memory; a lone access passes through with zero added latency.
// On a dual access, stall is raised for one cycle and EVEN then ODD is serviced; both lanes' load data return together.
module dmem_lane_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_even,
  input  logic             we_even,
  input  logic [AW-1:0]    addr_even,
  input  logic [DW-1:0]    wdata_even,
  output logic [DW-1:0]    rdata_even,
  input  logic             req_odd,
  input  logic             we_odd,
  input  logic [AW-1:0]    addr_odd,
  input  logic [DW-1:0]    wdata_odd,
  output logic [DW-1:0]    rdata_odd,
  output logic             stall,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_we,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {PASS, SECOND} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] hold_rdata;
  logic [AW-1:0] odd_addr;
  logic [DW-1:0] odd_wdata;
  logic          odd_we;
  logic          conflict;
  logic          stall_raw;
  logic          we_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PASS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    conflict   = 1'b0;
    stall_raw  = 1'b0;
    we_raw     = 1'b0;
    mem_addr   = addr_even;
    mem_wdata  = wdata_even;
    rdata_even = mem_rdata;
    rdata_odd  = mem_rdata;
    case (state)
      PASS: begin
        if (req_even && req_odd) begin
          conflict  = 1'b1;
          stall_raw = 1'b1;
          we_raw    = we_even;
          state_nxt = SECOND;
        end else if (req_odd) begin
          mem_addr  = addr_odd;
          mem_wdata = wdata_odd;
          we_raw    = we_odd;
        end else if (req_even) begin
          we_raw    = we_even;
        end
      end
      SECOND: begin
        // Lane inputs are ignored here; the frozen pipeline still holds them.
        mem_addr   = odd_addr;
        mem_wdata  = odd_wdata;
        we_raw     = odd_we;
        rdata_even = hold_rdata;
        state_nxt  = PASS;
      end
      default: state_nxt = PASS;
    endcase
  end

  // Gated combinationally so neither a write nor a freeze leaks out while in reset.
  assign mem_we = we_raw & reset;
  assign stall  = stall_raw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_rdata   <= '0;
      odd_addr     <= '0;
      odd_wdata    <= '0;
      odd_we       <= 1'b0;
      conflict_cnt <= '0;
    end else if (conflict) begin
      hold_rdata <= mem_rdata;
      odd_addr   <= addr_odd;
      odd_wdata  <= wdata_odd;
      odd_we     <= we_odd;
      if (conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
